rat_io_uart_tx: RTL and testbench

RAT_IO_UART_TX -- requirements
Module: rat_io_uart_tx

---
 rtl/rat_io_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_rat_io_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_io_uart_tx.sv
// rat_io_uart_tx: MCU-mapped 8N1 UART transmitter with a 4-entry TX FIFO,
// sticky DONE/OVF flags and a maskable level interrupt.
module rat_io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  BASE_ID      = 8'h40
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTR,
    output logic       TXD
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    localparam logic [7:0] ID_DATA = BASE_ID;
    localparam logic [7:0] ID_CTRL = BASE_ID + 8'd1;
    localparam logic [7:0] ID_STAT = BASE_ID + 8'd2;
    localparam logic [7:0] ID_CNT  = BASE_ID + 8'd3;
    localparam logic [7:0] ID_ACK  = BASE_ID + 8'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        fifo_q [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              int_en_q, int_en_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic wr_data, wr_ctrl, wr_ack;
    logic full, busy, pop, push, ovf_set, done_set, baud_end;

    assign wr_data  = IO_STRB && (PORT_ID == ID_DATA);
    assign wr_ctrl  = IO_STRB && (PORT_ID == ID_CTRL);
    assign wr_ack   = IO_STRB && (PORT_ID == ID_ACK);
    assign full     = (cnt_q == 3'd4);
    assign busy     = (state_q != S_IDLE);
    // The FSM only draws from the FIFO while idle, so a pop frees a slot
    // that a same-cycle push into a full FIFO may take.
    assign pop      = (state_q == S_IDLE) && (cnt_q != 3'd0);
    assign push     = wr_data && (!full || pop);
    assign ovf_set  = wr_data && full && !pop;
    assign baud_end = (baud_q == BAUD_LAST);

    // Frame sequencer: next state, baud/bit counters and shift register.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    state_d = S_START;
                    shift_d = fifo_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d   = '0;
                    state_d  = S_IDLE;
                    done_set = (cnt_q == 3'd0);
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
        endcase
    end

    // FIFO pointers, occupancy and the control/flag registers.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 3'd1;
        end
        int_en_d = wr_ctrl ? OUT_PORT[0] : int_en_q;
        // Set events win over a coincident acknowledge.
        done_d   = done_set ? 1'b1 : (wr_ack ? 1'b0 : done_q);
        ovf_d    = ovf_set  ? 1'b1 : (wr_ack ? 1'b0 : ovf_q);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            int_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            int_en_q <= int_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= OUT_PORT;
        end
    end

    // Read mux back to the MCU.
    always_comb begin
        IN_PORT = 8'h00;
        if (PORT_ID == ID_STAT) begin
            IN_PORT = {5'b0, ovf_q, full, busy};
        end else if (PORT_ID == ID_CNT) begin
            IN_PORT = {5'b0, cnt_q};
        end
    end

    // Serial line decoded from state so reset forces idle-high immediately.
    always_comb begin
        case (state_q)
            S_START: TXD = 1'b0;
            S_DATA:  TXD = shift_q[0];
            default: TXD = 1'b1;
        endcase
    end

    assign INTR = int_en_q & (done_q | ovf_q);

endmodule

// File: tb/tb_rat_io_uart_tx.sv
// Self-checking bench for rat_io_uart_tx (CLKS_PER_BIT=4, BASE_ID=8'h40).
module tb_rat_io_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INTR;
    logic       TXD;

    rat_io_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .BASE_ID     (8'h40)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IO_STRB (IO_STRB),
        .IN_PORT (IN_PORT),
        .INTR    (INTR),
        .TXD     (TXD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int frames_done = 0;
    int frames_started = 0;
    int cyc = 0;
    int starts[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        IO_STRB  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] v);
        PORT_ID = id;
        #1;
        v = IN_PORT;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("frames_done", frames_done, target);
        @(negedge CLK);
    endtask

    // Line monitor: every frame must match the next expected byte, each
    // level held for exactly CPB samples.
    initial begin
        logic       in_frame;
        int         idx;
        int         b;
        int         match;
        logic [7:0] cur;
        logic       lvl;
        in_frame = 1'b0;
        idx = 0;
        match = 0;
        cur = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET_N) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && TXD == 1'b0) begin
                    in_frame = 1'b1;
                    idx = 0;
                    match = 0;
                    frames_started++;
                    starts.push_back(cyc);
                    chk("frame_expected", exp_q.size() > 0, 1);
                    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                end
                if (in_frame) begin
                    b = idx / CPB;
                    lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                    if (TXD === lvl) match++;
                    if (idx % CPB == CPB - 1) begin
                        chk($sformatf("txd_f%0d_bit%0d_samples", frames_started, b), match, CPB);
                        match = 0;
                    end
                    idx++;
                    if (idx == FRAME) begin
                        in_frame = 1'b0;
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] wr_id;
        logic [7:0] wr_data;
        logic [7:0] rd_id;
        logic [7:0] exp_rd;
        logic       exp_intr;
        string      name;
    } vec_t;

    initial begin
        vec_t       vecs[10];
        logic [7:0] v;
        logic [7:0] burst[6];
        int         busy_cnt;
        int         base;
        int         s0;
        int         fs;
        logic       got;
        logic       prev_busy;

        // Entry state: DONE=1 (from the single-byte frame), OVF=0, INT_EN=0.
        vecs[0] = '{8'h41, 8'h01, 8'h42, 8'h00, 1'b1, "en_on"};
        vecs[1] = '{8'h41, 8'h00, 8'h43, 8'h00, 1'b0, "en_off_masks"};
        vecs[2] = '{8'h41, 8'h01, 8'h42, 8'h00, 1'b1, "en_on_done_kept"};
        vecs[3] = '{8'h42, 8'hFF, 8'h43, 8'h00, 1'b1, "wr_status_ro"};
        vecs[4] = '{8'h43, 8'hFF, 8'h50, 8'h00, 1'b1, "wr_count_ro"};
        vecs[5] = '{8'h45, 8'hFF, 8'h3F, 8'h00, 1'b1, "wr_unmapped_hi"};
        vecs[6] = '{8'h3F, 8'h01, 8'h44, 8'h00, 1'b1, "wr_unmapped_lo"};
        vecs[7] = '{8'h44, 8'h5A, 8'h42, 8'h00, 1'b0, "ack_clears"};
        vecs[8] = '{8'h41, 8'hFE, 8'h42, 8'h00, 1'b0, "en_bit0_only"};
        vecs[9] = '{8'h41, 8'h01, 8'h43, 8'h00, 1'b0, "en_on_no_flags"};
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        RESET_N  = 1'b1;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h42;
        OUT_PORT = 8'h00;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("reset_txd", TXD, 1);
        chk("reset_intr", INTR, 0);
        chk("reset_status", IN_PORT, 8'h00);
        rd(8'h43, v);
        chk("reset_count", v, 8'h00);

        // Single byte, written on the first edge after reset release.
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        exp_q.push_back(8'hA5);
        wr(8'h40, 8'hA5);
        rd(8'h43, v);
        chk("first_edge_push_count", v, 8'h01);
        PORT_ID = 8'h42;
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge CLK);
            if (IN_PORT[0]) busy_cnt++;
        end
        chk("single_busy_cycles", busy_cnt, FRAME);
        chk("single_frames", frames_done, 1);
        chk("single_txd_idle", TXD, 1);
        chk("single_intr_masked", INTR, 0);
        rd(8'h43, v);
        chk("single_count_after", v, 8'h00);

        // Port decode / control table.
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].wr_id, vecs[i].wr_data);
            rd(vecs[i].rd_id, v);
            chk({vecs[i].name, "_rd"}, v, vecs[i].exp_rd);
            chk({vecs[i].name, "_intr"}, INTR, vecs[i].exp_intr);
        end

        // Overflow burst, then a push into a full FIFO that coincides with a pop.
        base = frames_done;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(burst[i]);
            PORT_ID  = 8'h40;
            OUT_PORT = burst[i];
            IO_STRB  = 1'b1;
            @(negedge CLK);
        end
        IO_STRB = 1'b0;
        rd(8'h42, v);
        chk("ovf_status", v, 8'h07);
        rd(8'h43, v);
        chk("ovf_count", v, 8'h04);
        chk("ovf_intr", INTR, 1);
        wr(8'h44, 8'h00);
        rd(8'h42, v);
        chk("ovf_ack_status", v, 8'h03);
        chk("ovf_ack_intr", INTR, 0);
        repeat (35) @(negedge CLK);
        exp_q.push_back(8'h77);
        wr(8'h40, 8'h77);
        rd(8'h42, v);
        chk("full_push_pop_status", v, 8'h03);
        rd(8'h43, v);
        chk("full_push_pop_count", v, 8'h04);
        wait_frames(base + 6, 6 * (FRAME + 1) + 40);
        chk("drain_done_intr", INTR, 1);
        rd(8'h43, v);
        chk("drain_count", v, 8'h00);
        wr(8'h44, 8'h00);
        chk("drain_ack_intr", INTR, 0);

        // Back-to-back frames: one idle cycle between STOP end and next START.
        base = frames_done;
        s0 = starts.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        wr(8'h40, 8'h00);
        wr(8'h40, 8'hFF);
        wait_frames(base + 2, 2 * (FRAME + 1) + 20);
        chk("b2b_start_spacing", (starts.size() >= s0 + 2) ? starts[s0+1] - starts[s0] : -1, FRAME + 1);
        wr(8'h44, 8'h00);

        // Interrupt rises exactly as BUSY falls; acknowledge clears it.
        exp_q.push_back(8'h3C);
        wr(8'h40, 8'h3C);
        PORT_ID = 8'h42;
        got = 1'b0;
        prev_busy = 1'b0;
        for (int i = 0; i < FRAME + 20 && !got; i++) begin
            @(negedge CLK);
            if (INTR) begin
                got = 1'b1;
                chk("intr_rise_prev_busy", prev_busy, 1);
                chk("intr_rise_now_idle", IN_PORT[0], 0);
            end
            prev_busy = IN_PORT[0];
        end
        chk("intr_rise_seen", got, 1);
        wr(8'h44, 8'h00);
        chk("intr_ack_next_cycle", INTR, 0);

        // Acknowledge on the very edge DONE sets: DONE must survive.
        exp_q.push_back(8'h5A);
        wr(8'h40, 8'h5A);
        repeat (FRAME) @(negedge CLK);
        wr(8'h44, 8'h00);
        rd(8'h42, v);
        chk("coinc_ack_idle", v, 8'h00);
        chk("coinc_ack_intr", INTR, 1);
        wr(8'h44, 8'h00);
        chk("coinc_reack_intr", INTR, 0);

        // Readback with two entries queued behind an active frame.
        base = frames_done;
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3);
        wr(8'h40, 8'hA1);
        wr(8'h40, 8'hB2);
        wr(8'h40, 8'hC3);
        rd(8'h43, v);
        chk("readback_count2", v, 8'h02);
        rd(8'h50, v);
        chk("readback_unmapped", v, 8'h00);
        wait_frames(base + 3, 3 * (FRAME + 1) + 20);
        wr(8'h44, 8'h00);

        // Reset in the middle of data bit 3.
        exp_q.push_back(8'h96);
        wr(8'h40, 8'h96);
        repeat (18) @(negedge CLK);
        chk("pre_reset_txd_bit3", TXD, 0);
        #1;
        RESET_N = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_txd", TXD, 1);
        rd(8'h42, v);
        chk("midreset_status", v, 8'h00);
        rd(8'h43, v);
        chk("midreset_count", v, 8'h00);
        chk("midreset_intr", INTR, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        fs = frames_started;
        repeat (60) @(negedge CLK);
        chk("postreset_no_frame", frames_started, fs);
        chk("postreset_txd", TXD, 1);
        rd(8'h42, v);
        chk("postreset_status", v, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
